// File: rtl/dualmem_line_pkg.sv
// ----------------------------------------------------------------------------
// dualmem_line_pkg
//
// Purpose:
//   Shared widths, the FSM state type and the line type for the port-B
//   line transfer client of the 512 x 1260-bit dual-port line RAM.
//   A line is 35 beats of 36 bits; beat k lives at line bits [k*36 +: 36].
//
// Contents:
//   ADDR_W, BEAT_W, BEATS, LINE_W, CNT_W  widths
//   LAST_BEAT                             index of the final beat (34)
//   state_e                               transfer FSM states
//   line_t                                one full RAM line
//   beat_offset()                         bit offset of a beat in a line
// ----------------------------------------------------------------------------
package dualmem_line_pkg;

    localparam int ADDR_W = 9;
    localparam int BEAT_W = 36;
    localparam int BEATS  = 35;
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_RD_STREAM,
        ST_WR_FILL,
        ST_WR_COMMIT
    } state_e;

    typedef logic [LINE_W-1:0] line_t;

    // 11 bits covers the largest offset, 34*36 = 1224.
    function automatic logic [10:0] beat_offset(input logic [CNT_W-1:0] cnt);
        return 11'(cnt) * 11'(BEAT_W);
    endfunction

endpackage

// File: rtl/dualmem_line_xfer.sv
// ----------------------------------------------------------------------------
// dualmem_line_xfer
//
// Purpose:
//   Port-B client for the 512 x 1260-bit dual-port line RAM. A read command
//   fetches one line in a single RAM access and streams it out as 35 beats of
//   36 bits. A write command gathers 35 beats into the line buffer and
//   commits the whole line in a single RAM write cycle. One command is in
//   flight at a time and every command runs to completion.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   cmd_valid/ready           command handshake
//   cmd_write, cmd_addr       1 = write line, 0 = read line; line address
//   wdata_valid/ready, wdata  write beat stream (beat k -> bits [k*36 +: 36])
//   rdata_valid/ready, rdata  read beat stream, rdata is 0 when not valid
//   rdata_last                marks beat 34
//   done                      one-cycle pulse when a command completes
//   mem_en, mem_we, mem_addr  RAM port control and latched line address
//   mem_din                   RAM write data, always the line buffer
//   mem_dout                  RAM read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module dualmem_line_xfer
    import dualmem_line_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [BEAT_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [BEAT_W-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_din,
    input  logic [LINE_W-1:0] mem_dout
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    line_t              buf_q, buf_d;
    logic [10:0]        beat_off;

    // Bit position of the current beat inside the line buffer.
    assign beat_off = beat_offset(cnt_q);

    // The RAM always sees the latched address and the whole line buffer;
    // only mem_en/mem_we decide whether anything happens on the port.
    assign mem_addr = addr_q;
    assign mem_din  = buf_q;

    // State, beat counter, address and line buffer. Reset drops whatever
    // command was in flight: no RAM write is ever issued for a partial fill
    // and a stream being read simply stops.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and output decode. All handshake outputs depend only on the
    // registered state; the read-side done pulse is the one output that also
    // looks at rdata_ready, because it marks the cycle the last beat is taken.
    // The counter stops at the last beat rather than incrementing, so it
    // never reaches 35; it is cleared again when the next command is taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        rdata_last  = 1'b0;
        done        = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = '0;
                    state_d = cmd_write ? ST_WR_FILL : ST_RD_ISSUE;
                end
            end

            ST_RD_ISSUE: begin
                mem_en  = 1'b1;
                state_d = ST_RD_CAPTURE;
            end

            // The RAM output is registered, so the line is only valid here,
            // one cycle after the read was issued.
            ST_RD_CAPTURE: begin
                buf_d   = mem_dout;
                state_d = ST_RD_STREAM;
            end

            ST_RD_STREAM: begin
                rdata_valid = 1'b1;
                rdata       = buf_q[beat_off +: BEAT_W];
                rdata_last  = (cnt_q == LAST_BEAT);
                if (rdata_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_WR_FILL: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    buf_d[beat_off +: BEAT_W] = wdata;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_WR_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_WR_COMMIT: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dualmem_line_xfer.sv
// ----------------------------------------------------------------------------
// tb_dualmem_line_xfer
//
// Directed bench for dualmem_line_xfer with a behavioural 512-line RAM
// (registered read, one-cycle write) attached to the client's port.
// ----------------------------------------------------------------------------
module tb_dualmem_line_xfer;
    import dualmem_line_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [BEAT_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [BEAT_W-1:0] rdata;
    logic              rdata_last;
    logic              done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_din;
    logic [LINE_W-1:0] mem_dout;

    int vectors     = 0;
    int miscompares = 0;

    // Free-running cycle number, plus port activity seen by the monitor.
    int    cycleNo   = 0;
    int    enCount   = 0;
    int    weCount   = 0;
    int    doneCount = 0;
    int    doneCycle = -1;
    int    weCycle   = -1;
    logic [ADDR_W-1:0] weAddr = '0;
    line_t weData = '0;

    // Side door used only to preload lines before traffic starts.
    logic              preloadEn = 1'b0;
    logic [ADDR_W-1:0] preloadAddr = '0;
    line_t             preloadData = '0;

    line_t ram [512];

    always #5 clk = ~clk;

    dualmem_line_xfer dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .done        (done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    // RAM model: registered read data, write takes effect at the clock edge.
    always @(posedge clk) begin
        if (preloadEn) begin
            ram[preloadAddr] <= preloadData;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout      <= ram[mem_addr];
        end
    end

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_en) enCount <= enCount + 1;
        if (mem_en && mem_we) begin
            weCount <= weCount + 1;
            weAddr  <= mem_addr;
            weData  <= mem_din;
            weCycle <= cycleNo;
        end
        if (done) begin
            doneCount <= doneCount + 1;
            doneCycle <= cycleNo;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
        $fatal(1, "[TB] watchdog");
    end

    function automatic line_t make_line(input logic [35:0] base, input logic [35:0] step);
        line_t l;
        l = '0;
        for (int k = 0; k < BEATS; k++) l[k*36 +: 36] = base + step * 36'(k);
        return l;
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] addr, input line_t data);
        preloadEn   = 1'b1;
        preloadAddr = addr;
        preloadData = data;
        @(posedge clk); #1;
        preloadEn   = 1'b0;
    endtask

    // Issues one read and collects the stream. With toggle set, rdata_ready
    // follows the pattern 1,0,0,1 cycle by cycle.
    task automatic run_read(input logic [ADDR_W-1:0] addr, input bit toggle,
                            output line_t got, output int acceptCyc, output int firstCyc,
                            output int beats, output int lastErrs, output int stallErrs,
                            output int busyErrs, output logic enAt1, output bit timeout);
        logic [35:0] held;
        logic [3:0]  patv;
        bit          stalled;
        bit          hs;
        int          guard;
        patv = 4'b1001; got = '0; beats = 0; lastErrs = 0; stallErrs = 0; busyErrs = 0;
        enAt1 = 1'b0; timeout = 1'b0; firstCyc = -1; acceptCyc = -1; held = '0;
        stalled = 1'b0; guard = 0; hs = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; rdata_ready = 1'b1;
        while (!hs && guard < 50) begin
            @(negedge clk);
            hs = cmd_ready;
            if (hs) acceptCyc = cycleNo;
            @(posedge clk); #1;
            guard++;
        end
        cmd_valid = 1'b0;
        if (!hs) begin
            timeout = 1'b1;
            return;
        end
        guard = 0;
        while (beats < 35 && guard < 300) begin
            rdata_ready = toggle ? patv[guard % 4] : 1'b1;
            @(negedge clk);
            if (cycleNo == acceptCyc + 1) enAt1 = mem_en & ~mem_we;
            if (cmd_ready) busyErrs++;
            if (rdata_valid) begin
                if (firstCyc < 0) firstCyc = cycleNo;
                if (stalled && rdata !== held) stallErrs++;
                if (rdata_ready) begin
                    got[beats*36 +: 36] = rdata;
                    if (rdata_last !== (beats == 34) || done !== (beats == 34)) lastErrs++;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    if (done !== 1'b0) lastErrs++;
                    held    = rdata;
                    stalled = 1'b1;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        rdata_ready = 1'b0;
        if (beats < 35) timeout = 1'b1;
    endtask

    // Issues one write and offers nbeats beats; with gaps set, beat k is
    // preceded by k%4 idle cycles. A full write returns in the first idle
    // cycle after the commit.
    task automatic run_write(input logic [ADDR_W-1:0] addr, input line_t line, input bit gaps,
                             input int nbeats, output int acceptCyc, output int beats,
                             output int busyErrs, output int enEarly, output bit timeout);
        bit hs;
        int guard;
        acceptCyc = -1; beats = 0; busyErrs = 0; enEarly = 0; timeout = 1'b0;
        hs = 1'b0; guard = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr;
        while (!hs && guard < 50) begin
            @(negedge clk);
            hs = cmd_ready;
            if (hs) acceptCyc = cycleNo;
            @(posedge clk); #1;
            guard++;
        end
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        if (!hs) begin
            timeout = 1'b1;
            return;
        end
        for (int k = 0; k < nbeats && !timeout; k++) begin
            wdata_valid = 1'b0;
            if (gaps) begin
                for (int g = 0; g < k % 4; g++) begin
                    @(negedge clk);
                    if (cmd_ready) busyErrs++;
                    if (mem_en) enEarly++;
                    @(posedge clk); #1;
                end
            end
            wdata_valid = 1'b1;
            wdata = line[k*36 +: 36];
            hs = 1'b0; guard = 0;
            while (!hs && guard < 100) begin
                @(negedge clk);
                hs = wdata_ready;
                if (cmd_ready) busyErrs++;
                if (mem_en) enEarly++;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) timeout = 1'b1;
            else beats++;
        end
        wdata_valid = 1'b0;
        if (nbeats == 35 && !timeout) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cmd_ready got=%0b want=1", cmd_ready); end
        vectors++; if (wdata_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wdata_ready got=%0b want=0", wdata_ready); end
        vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdata_valid got=%0b want=0", rdata_valid); end
        vectors++; if (rdata_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdata_last got=%0b want=0", rdata_last); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
        vectors++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_en_we got=%0b%0b want=00", mem_en, mem_we); end
        vectors++; if (rdata !== '0) begin miscompares++; $display("[TB] FAIL reset_rdata got=%h want=0", rdata); end
        vectors++; if (mem_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got=%h want=0", mem_addr); end
        vectors++; if (mem_din !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_din nonzero, want=0"); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic;
        line_t got, exp;
        int acc, first, beats, lastErrs, stallErrs, busyErrs, done0, en0, we0;
        logic enAt1;
        bit to;
        exp = make_line(36'hA_1000_0000, 36'h1);
        done0 = doneCount; en0 = enCount; we0 = weCount;
        run_read(9'h1A5, 1'b0, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_basic_timeout beats=%0d want=35", beats); end
        vectors++; if (first - acc !== 3) begin miscompares++; $display("[TB] FAIL rd_basic_latency got=%0d want=3", first - acc); end
        vectors++; if (enAt1 !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_basic_mem_en_cycle1 got=%0b want=1", enAt1); end
        vectors++; if (got !== exp) begin miscompares++; $display("[TB] FAIL rd_basic_data beat0 got=%h want=%h", got[35:0], exp[35:0]); end
        vectors++; if (lastErrs !== 0) begin miscompares++; $display("[TB] FAIL rd_basic_last_done errors=%0d want=0", lastErrs); end
        vectors++; if (doneCycle - acc !== 37) begin miscompares++; $display("[TB] FAIL rd_basic_duration got=%0d want=37", doneCycle - acc); end
        vectors++; if (doneCount - done0 !== 1) begin miscompares++; $display("[TB] FAIL rd_basic_done_count got=%0d want=1", doneCount - done0); end
        vectors++; if (enCount - en0 !== 1 || weCount - we0 !== 0) begin miscompares++; $display("[TB] FAIL rd_basic_port_use en=%0d we=%0d want=1,0", enCount - en0, weCount - we0); end
        vectors++; if (busyErrs !== 0) begin miscompares++; $display("[TB] FAIL rd_basic_busy_ready got=%0d want=0", busyErrs); end
    endtask

    task automatic test_write_basic;
        line_t exp, got;
        int acc, beats, busyErrs, enEarly, done0, we0, first, lastErrs, stallErrs;
        logic enAt1;
        bit to;
        exp = make_line(36'h0_CAFE_0000, 36'h1);
        done0 = doneCount; we0 = weCount;
        run_write(9'h003, exp, 1'b0, 35, acc, beats, busyErrs, enEarly, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_basic_timeout beats=%0d want=35", beats); end
        vectors++; if (weCount - we0 !== 1) begin miscompares++; $display("[TB] FAIL wr_basic_we_pulses got=%0d want=1", weCount - we0); end
        vectors++; if (weAddr !== 9'h003) begin miscompares++; $display("[TB] FAIL wr_basic_addr got=%h want=003", weAddr); end
        vectors++; if (weData !== exp) begin miscompares++; $display("[TB] FAIL wr_basic_din beat0 got=%h want=%h", weData[35:0], exp[35:0]); end
        vectors++; if (weCycle - acc !== 36) begin miscompares++; $display("[TB] FAIL wr_basic_commit_cycle got=%0d want=36", weCycle - acc); end
        vectors++; if (doneCount - done0 !== 1 || doneCycle !== weCycle) begin miscompares++; $display("[TB] FAIL wr_basic_done n=%0d at=%0d want=1 at %0d", doneCount - done0, doneCycle, weCycle); end
        vectors++; if (busyErrs !== 0 || enEarly !== 0) begin miscompares++; $display("[TB] FAIL wr_basic_busy ready=%0d en=%0d want=0,0", busyErrs, enEarly); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_basic_ready_cycle37 got=%0b want=1", cmd_ready); end
        vectors++; if (mem_din !== exp) begin miscompares++; $display("[TB] FAIL wr_basic_din_hold beat0 got=%h want=%h", mem_din[35:0], exp[35:0]); end
        run_read(9'h003, 1'b0, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        vectors++; if (to !== 1'b0 || got !== exp) begin miscompares++; $display("[TB] FAIL wr_basic_readback beat0 got=%h want=%h", got[35:0], exp[35:0]); end
    endtask

    task automatic test_read_stall;
        line_t exp, got;
        int acc, first, beats, lastErrs, stallErrs, busyErrs, done0;
        logic enAt1;
        bit to;
        exp = make_line(36'h0_CAFE_0000, 36'h1);
        done0 = doneCount;
        run_read(9'h003, 1'b1, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_stall_timeout beats=%0d want=35", beats); end
        vectors++; if (got !== exp) begin miscompares++; $display("[TB] FAIL rd_stall_data beat34 got=%h want=%h", got[34*36 +: 36], exp[34*36 +: 36]); end
        vectors++; if (stallErrs !== 0) begin miscompares++; $display("[TB] FAIL rd_stall_stable errors=%0d want=0", stallErrs); end
        vectors++; if (lastErrs !== 0) begin miscompares++; $display("[TB] FAIL rd_stall_last_done errors=%0d want=0", lastErrs); end
        vectors++; if (doneCount - done0 !== 1) begin miscompares++; $display("[TB] FAIL rd_stall_done_count got=%0d want=1", doneCount - done0); end
    endtask

    task automatic test_write_gaps;
        line_t exp, got;
        int acc, beats, busyErrs, enEarly, we0, first, lastErrs, stallErrs;
        logic enAt1;
        bit to;
        exp = make_line(36'h3_0000_0100, 36'h11);
        we0 = weCount;
        run_write(9'h0C0, exp, 1'b1, 35, acc, beats, busyErrs, enEarly, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_gaps_timeout beats=%0d want=35", beats); end
        vectors++; if (enEarly !== 0) begin miscompares++; $display("[TB] FAIL wr_gaps_early_en got=%0d want=0", enEarly); end
        vectors++; if (weCount - we0 !== 1 || weAddr !== 9'h0C0) begin miscompares++; $display("[TB] FAIL wr_gaps_commit n=%0d addr=%h want=1,0c0", weCount - we0, weAddr); end
        vectors++; if (weData !== exp) begin miscompares++; $display("[TB] FAIL wr_gaps_din beat5 got=%h want=%h", weData[5*36 +: 36], exp[5*36 +: 36]); end
        run_read(9'h0C0, 1'b0, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        vectors++; if (to !== 1'b0 || got !== exp) begin miscompares++; $display("[TB] FAIL wr_gaps_readback beat5 got=%h want=%h", got[5*36 +: 36], exp[5*36 +: 36]); end
    endtask

    task automatic test_reset_mid_write;
        line_t newLine, oldLine, got;
        int acc, beats, busyErrs, enEarly, we0, done0, first, lastErrs, stallErrs;
        logic enAt1;
        bit to;
        newLine = make_line(36'hF_DEAD_0000, 36'h1);
        oldLine = make_line(36'hA_1000_0000, 36'h1);
        we0 = weCount; done0 = doneCount;
        run_write(9'h1A5, newLine, 1'b0, 17, acc, beats, busyErrs, enEarly, to);
        vectors++; if (to !== 1'b0 || beats !== 17) begin miscompares++; $display("[TB] FAIL rst_wr_partial beats=%0d want=17", beats); end
        // Beat 17 is on offer when reset hits.
        wdata_valid = 1'b1;
        wdata = newLine[17*36 +: 36];
        rstn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rstn = 1'b1;
        wdata_valid = 1'b0;
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1 || wdata_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_wr_idle cmd_ready=%0b wdata_ready=%0b want=1,0", cmd_ready, wdata_ready); end
        vectors++; if (mem_din !== '0 || mem_addr !== '0) begin miscompares++; $display("[TB] FAIL rst_wr_cleared addr=%h want=0 and din zero", mem_addr); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (weCount - we0 !== 0 || doneCount - done0 !== 0) begin miscompares++; $display("[TB] FAIL rst_wr_no_commit we=%0d done=%0d want=0,0", weCount - we0, doneCount - done0); end
        run_read(9'h1A5, 1'b0, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        vectors++; if (to !== 1'b0 || got !== oldLine) begin miscompares++; $display("[TB] FAIL rst_wr_old_line beat0 got=%h want=%h", got[35:0], oldLine[35:0]); end
    endtask

    task automatic test_back_to_back;
        line_t ffLine, wrLine, got;
        int acc, acc2, first, beats, lastErrs, stallErrs, busyErrs, enEarly, done0, rdDone;
        logic enAt1;
        bit to;
        ffLine = make_line(36'h7_7700_0000, 36'h1);
        wrLine = make_line(36'h2_BEEF_0000, 36'h1);
        done0 = doneCount;
        run_read(9'h1FF, 1'b0, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        rdDone = doneCycle;
        vectors++; if (to !== 1'b0 || got !== ffLine || busyErrs !== 0) begin miscompares++; $display("[TB] FAIL b2b_read1 beat0 got=%h want=%h busy=%0d", got[35:0], ffLine[35:0], busyErrs); end
        run_write(9'h1FF, wrLine, 1'b0, 35, acc2, beats, busyErrs, enEarly, to);
        vectors++; if (acc2 - rdDone !== 1) begin miscompares++; $display("[TB] FAIL b2b_accept_gap got=%0d want=1", acc2 - rdDone); end
        vectors++; if (to !== 1'b0 || busyErrs !== 0 || weAddr !== 9'h1FF || weData !== wrLine) begin miscompares++; $display("[TB] FAIL b2b_write addr=%h busy=%0d want=1ff,0", weAddr, busyErrs); end
        run_read(9'h1FF, 1'b0, got, acc, first, beats, lastErrs, stallErrs, busyErrs, enAt1, to);
        vectors++; if (to !== 1'b0 || got !== wrLine || busyErrs !== 0) begin miscompares++; $display("[TB] FAIL b2b_read2 beat0 got=%h want=%h busy=%0d", got[35:0], wrLine[35:0], busyErrs); end
        vectors++; if (doneCount - done0 !== 3) begin miscompares++; $display("[TB] FAIL b2b_done_count got=%0d want=3", doneCount - done0); end
    endtask

    initial begin
        rstn        = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b0;
        @(posedge clk); #1;
        preload(9'h1A5, make_line(36'hA_1000_0000, 36'h1));
        preload(9'h1FF, make_line(36'h7_7700_0000, 36'h1));
        test_reset();
        test_read_basic();
        test_write_basic();
        test_read_stall();
        test_write_gaps();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
